// File: rtl/pan_voice_scheduler.sv
// Time-multiplexed voice scheduler: issues each enabled voice to a shared panning
// datapath and accumulates a stereo mix. Define PAN_SCHED_SAT_EN to saturate the mix.
module pan_voice_scheduler #(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     frame_start,
    input  logic [NUM_VOICES-1:0]    voice_en,
    input  logic [16*NUM_VOICES-1:0] voice_samples,
    output logic [15:0]              pan_sample,
    output logic                     pan_in_ready,
    input  logic [15:0]              pan_out_L,
    input  logic [15:0]              pan_out_R,
    input  logic                     pan_out_ready,
    output logic [15:0]              mix_L,
    output logic [15:0]              mix_R,
    output logic                     mix_valid,
    output logic                     busy,
    output logic                     timeout_err,
    output logic                     overrun
);
    localparam int unsigned SW = 16;
    localparam int unsigned AW = 19;
    localparam int unsigned IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
`ifdef PAN_SCHED_SAT_EN
    localparam logic signed [AW-1:0] SAT_MAX = AW'(32767);
    localparam logic signed [AW-1:0] SAT_MIN = AW'(-32768);
`endif

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LATCH = 3'd1,
        SCAN  = 3'd2,
        ISSUE = 3'd3,
        WAIT  = 3'd4,
        ACCUM = 3'd5,
        DONE  = 3'd6
    } state_t;

    state_t state, state_d;

    logic [IW-1:0]         idx, idx_d;
    logic [CW-1:0]         cnt, cnt_d;
    logic [NUM_VOICES-1:0] en_q, en_d;
    logic [SW-1:0]         smp_q [NUM_VOICES];
    logic [SW-1:0]         smp_d [NUM_VOICES];
    logic [SW-1:0]         cap_l, cap_l_d, cap_r, cap_r_d;
    logic                  cap_ok, cap_ok_d;
    logic signed [AW-1:0]  acc_l, acc_l_d, acc_r, acc_r_d;
    logic [SW-1:0]         pan_sample_d, mix_l_d, mix_r_d;
    logic                  pan_in_ready_d, mix_valid_d, busy_d, timeout_d, overrun_d;
    logic                  last_voice, wait_expired;

    assign last_voice   = (idx == IW'(NUM_VOICES - 1));
    assign wait_expired = (cnt == CW'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (frame_start) state_d = LATCH;
            LATCH:   state_d = SCAN;
            SCAN: begin
                if (en_q[idx])       state_d = ISSUE;
                else if (last_voice) state_d = DONE;
            end
            ISSUE:   state_d = WAIT;
            WAIT:    if (pan_out_ready || wait_expired) state_d = ACCUM;
            ACCUM:   state_d = last_voice ? DONE : SCAN;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        idx_d          = idx;
        cnt_d          = cnt;
        en_d           = en_q;
        smp_d          = smp_q;
        cap_l_d        = cap_l;
        cap_r_d        = cap_r;
        cap_ok_d       = cap_ok;
        acc_l_d        = acc_l;
        acc_r_d        = acc_r;
        pan_sample_d   = pan_sample;
        pan_in_ready_d = 1'b0;
        mix_l_d        = mix_L;
        mix_r_d        = mix_R;
        mix_valid_d    = 1'b0;
        busy_d         = (state_d != IDLE);
        timeout_d      = timeout_err;
        overrun_d      = overrun;

        if (frame_start && (state != IDLE)) overrun_d = 1'b1;

        case (state)
            LATCH: begin
                en_d    = voice_en;
                for (int i = 0; i < NUM_VOICES; i++) smp_d[i] = voice_samples[i*SW +: SW];
                acc_l_d = '0;
                acc_r_d = '0;
                idx_d   = '0;
                cnt_d   = '0;
            end
            SCAN:  if (!en_q[idx] && !last_voice) idx_d = idx + IW'(1);
            ISSUE: cnt_d = '0;
            WAIT: begin
                if (pan_out_ready) begin
                    cap_l_d  = pan_out_L;
                    cap_r_d  = pan_out_R;
                    cap_ok_d = 1'b1;
                end else if (wait_expired) begin
                    cap_ok_d  = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            ACCUM: begin
                if (cap_ok) begin
                    acc_l_d = acc_l + AW'($signed(cap_l));
                    acc_r_d = acc_r + AW'($signed(cap_r));
                end
                if (!last_voice) idx_d = idx + IW'(1);
            end
            default: ;
        endcase

        if (state_d == ISSUE) begin
            pan_in_ready_d = 1'b1;
            pan_sample_d   = smp_q[idx];
        end

        // Mix is loaded so that it is visible together with the DONE pulse
        if (state_d == DONE) begin
            mix_valid_d = 1'b1;
`ifdef PAN_SCHED_SAT_EN
            if (acc_l_d > SAT_MAX)      mix_l_d = 16'h7fff;
            else if (acc_l_d < SAT_MIN) mix_l_d = 16'h8000;
            else                        mix_l_d = acc_l_d[SW-1:0];
            if (acc_r_d > SAT_MAX)      mix_r_d = 16'h7fff;
            else if (acc_r_d < SAT_MIN) mix_r_d = 16'h8000;
            else                        mix_r_d = acc_r_d[SW-1:0];
`else
            mix_l_d = acc_l_d[SW-1:0];
            mix_r_d = acc_r_d[SW-1:0];
`endif
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx          <= '0;
            cnt          <= '0;
            en_q         <= '0;
            for (int i = 0; i < NUM_VOICES; i++) smp_q[i] <= '0;
            cap_l        <= '0;
            cap_r        <= '0;
            cap_ok       <= 1'b0;
            acc_l        <= '0;
            acc_r        <= '0;
            pan_sample   <= '0;
            pan_in_ready <= 1'b0;
            mix_L        <= '0;
            mix_R        <= '0;
            mix_valid    <= 1'b0;
            busy         <= 1'b0;
            timeout_err  <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            idx          <= idx_d;
            cnt          <= cnt_d;
            en_q         <= en_d;
            smp_q        <= smp_d;
            cap_l        <= cap_l_d;
            cap_r        <= cap_r_d;
            cap_ok       <= cap_ok_d;
            acc_l        <= acc_l_d;
            acc_r        <= acc_r_d;
            pan_sample   <= pan_sample_d;
            pan_in_ready <= pan_in_ready_d;
            mix_L        <= mix_l_d;
            mix_R        <= mix_r_d;
            mix_valid    <= mix_valid_d;
            busy         <= busy_d;
            timeout_err  <= timeout_d;
            overrun      <= overrun_d;
        end
    end

endmodule

// File: tb/tb_pan_voice_scheduler.sv
// Self-checking bench for pan_voice_scheduler: a frame-level timing/mix model predicts
// every output per cycle; directed frames pin the model, then randomized frames follow.
module tb_pan_voice_scheduler;
    localparam int NV   = 4;
    localparam int TO   = 15;
    localparam int MAXC = 12000;

    logic             clk           = 1'b0;
    logic             reset         = 1'b0;
    logic             frame_start   = 1'b0;
    logic [NV-1:0]    voice_en      = '0;
    logic [16*NV-1:0] voice_samples = '0;
    logic [15:0]      pan_sample;
    logic             pan_in_ready;
    logic [15:0]      pan_out_L     = '0;
    logic [15:0]      pan_out_R     = '0;
    logic             pan_out_ready = 1'b0;
    logic [15:0]      mix_L, mix_R;
    logic             mix_valid, busy, timeout_err, overrun;

    pan_voice_scheduler #(.NUM_VOICES(NV), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .voice_en(voice_en),
        .voice_samples(voice_samples), .pan_sample(pan_sample), .pan_in_ready(pan_in_ready),
        .pan_out_L(pan_out_L), .pan_out_R(pan_out_R), .pan_out_ready(pan_out_ready),
        .mix_L(mix_L), .mix_R(mix_R), .mix_valid(mix_valid), .busy(busy),
        .timeout_err(timeout_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle expectations written by the frame model
    bit          exp_pir  [MAXC];
    logic [15:0] exp_ps   [MAXC];
    int          exp_voice[MAXC];
    bit          exp_mv   [MAXC];
    logic [15:0] exp_ml   [MAXC];
    logic [15:0] exp_mr   [MAXC];
    bit          exp_busy [MAXC];
    bit          exp_to   [MAXC];
    bit          exp_ov   [MAXC];

    int          lat [NV];
    logic [15:0] lmask, loff, rmask, roff;
    int          frame_end = -1;
    int          f_cyc = 0;
    int          n_issue = 0, n_mv = 0, last_mv_cyc = -1;
    int          total = 0, bad = 0;
    int          resp_cyc = -1;
    int          rv;
    logic [15:0] resp_l, resp_r;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, want);
        end
    endtask

    function automatic logic [15:0] resp_of(input logic [15:0] s, input logic [15:0] m,
                                            input logic [15:0] o);
        return (s & m) + o;
    endfunction

    function automatic logic [15:0] fold(input int v);
`ifdef PAN_SCHED_SAT_EN
        if (v > 32767)  return 16'h7fff;
        if (v < -32768) return 16'h8000;
`endif
        return 16'(v);
    endfunction

    // Walk the voices in order, laying out issue/wait/accumulate/done cycles
    task automatic plan_frame(input int f, input logic [NV-1:0] en, input logic [16*NV-1:0] smp);
        int cur, iss, nxt, done, sl, sr;
        logic [15:0] s;
        cur = f + 2; sl = 0; sr = 0; done = 0;
        for (int i = 0; i < NV; i++) begin
            s = smp[i*16 +: 16];
            if (en[i]) begin
                iss = cur + 1;
                exp_pir[iss] = 1'b1; exp_ps[iss] = s; exp_voice[iss] = i;
                if (lat[i] >= 1 && lat[i] <= TO) begin
                    nxt = iss + lat[i] + 2;
                    sl = sl + int'($signed(resp_of(s, lmask, loff)));
                    sr = sr + int'($signed(resp_of(s, rmask, roff)));
                end else begin
                    exp_to[iss + TO + 1] = 1'b1;
                    nxt = iss + TO + 2;
                end
            end else begin
                nxt = cur + 1;
            end
            if (i == NV - 1) done = nxt;
            else             cur  = nxt;
        end
        for (int c = f + 1; c <= done; c++) exp_busy[c] = 1'b1;
        exp_mv[done] = 1'b1;
        exp_ml[done] = fold(sl);
        exp_mr[done] = fold(sr);
        frame_end = done;
    endtask

    // Datapath responder: answers lat[voice] cycles after each issue (0 = never)
    always @(negedge clk) begin
        if (reset && pan_in_ready) begin
            rv = exp_voice[cyc];
            if (lat[rv] >= 1) begin
                resp_cyc = cyc + lat[rv];
                resp_l   = resp_of(pan_sample, lmask, loff);
                resp_r   = resp_of(pan_sample, rmask, roff);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (cyc == resp_cyc) begin
            pan_out_ready = 1'b1; pan_out_L = resp_l; pan_out_R = resp_r;
        end else begin
            pan_out_ready = 1'b0; pan_out_L = 16'($urandom); pan_out_R = 16'($urandom);
        end
    end

    // Compare process
    logic [15:0] cur_ps = '0, cur_ml = '0, cur_mr = '0;
    bit cur_to = 1'b0, cur_ov = 1'b0, e_pir, e_mv, e_busy;
    always @(negedge clk) begin
        if (!reset) begin
            cur_ps = '0; cur_ml = '0; cur_mr = '0; cur_to = 1'b0; cur_ov = 1'b0;
            e_pir = 1'b0; e_mv = 1'b0; e_busy = 1'b0;
        end else begin
            if (exp_pir[cyc]) cur_ps = exp_ps[cyc];
            if (exp_mv[cyc]) begin cur_ml = exp_ml[cyc]; cur_mr = exp_mr[cyc]; end
            if (exp_to[cyc]) cur_to = 1'b1;
            if (exp_ov[cyc]) cur_ov = 1'b1;
            e_pir = exp_pir[cyc]; e_mv = exp_mv[cyc]; e_busy = exp_busy[cyc];
            if (pan_in_ready) n_issue++;
            if (mix_valid) begin n_mv++; last_mv_cyc = cyc; end
        end
        chk("pan_in_ready", 32'(pan_in_ready), 32'(e_pir));
        chk("pan_sample",   32'(pan_sample),   32'(cur_ps));
        chk("mix_valid",    32'(mix_valid),    32'(e_mv));
        chk("mix_L",        32'(mix_L),        32'(cur_ml));
        chk("mix_R",        32'(mix_R),        32'(cur_mr));
        chk("busy",         32'(busy),         32'(e_busy));
        chk("timeout_err",  32'(timeout_err),  32'(cur_to));
        chk("overrun",      32'(overrun),      32'(cur_ov));
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic rnd_inputs();
        voice_en      = NV'($urandom);
        voice_samples = {$urandom, $urandom};
    endtask

    task automatic set_resp(input logic [15:0] lm, input logic [15:0] lo,
                            input logic [15:0] rm, input logic [15:0] ro);
        lmask = lm; loff = lo; rmask = rm; roff = ro;
    endtask

    // Inputs held through the LATCH cycle, then scrambled for the rest of the frame
    task automatic launch(input logic [NV-1:0] en, input logic [16*NV-1:0] smp);
        f_cyc = cyc; n_issue = 0; n_mv = 0;
        voice_en = en; voice_samples = smp; frame_start = 1'b1;
        plan_frame(cyc, en, smp);
        tick(); frame_start = 1'b0;
        tick(); rnd_inputs();
    endtask

    task automatic finish_frame(input int ov_at, input int rst_at);
        while (cyc <= frame_end) begin
            if (ov_at >= 0 && cyc == f_cyc + ov_at && exp_busy[cyc]) begin
                frame_start = 1'b1; exp_ov[cyc + 1] = 1'b1;
            end
            if (rst_at >= 0 && cyc == f_cyc + rst_at) begin
                reset = 1'b0;
                for (int c = cyc; c <= frame_end + 1; c++) begin
                    exp_pir[c] = 1'b0; exp_mv[c] = 1'b0; exp_busy[c] = 1'b0;
                    exp_to[c] = 1'b0; exp_ov[c] = 1'b0;
                end
                resp_cyc = -1; frame_start = 1'b0;
                tick(); tick(); reset = 1'b1; tick();
                return;
            end
            tick(); frame_start = 1'b0; rnd_inputs();
        end
    endtask

    initial begin
        int r, nfr;
        logic [15:0] e36;
        e36 = 16'hA000;
`ifdef PAN_SCHED_SAT_EN
        e36 = 16'h7FFF;
`endif
        lat = '{1, 1, 1, 1};
        set_resp('1, '0, '1, '0);
        repeat (3) tick();
        reset = 1'b1;
        tick();

        // Four voices, L=R=sample, two-cycle datapath
        lat = '{2, 2, 2, 2};
        launch(4'hF, {16'h4000, 16'h3000, 16'h2000, 16'h1000});
        finish_frame(-1, -1);
        chk("all_voices_mix_L", 32'(mix_L), 32'(e36));
        chk("all_voices_mix_R", 32'(mix_R), 32'(e36));
        chk("all_voices_issues", 32'(n_issue), 32'd4);

        // Voices 0 and 2 only, constant datapath results
        lat = '{3, 1, 2, 4};
        set_resp('0, 16'h0100, '0, 16'h0200);
        launch(4'b0101, {$urandom, $urandom});
        finish_frame(-1, -1);
        chk("sparse_mix_L", 32'(mix_L), 32'h0200);
        chk("sparse_mix_R", 32'(mix_R), 32'h0400);
        chk("sparse_issues", 32'(n_issue), 32'd2);

        // Nothing enabled
        launch(4'b0000, {$urandom, $urandom});
        finish_frame(-1, -1);
        chk("idle_latency", 32'(last_mv_cyc - f_cyc), 32'd6);
        chk("idle_issues", 32'(n_issue), 32'd0);
        chk("idle_mix_L", 32'(mix_L), 32'h0000);

        // Second frame_start while busy
        lat = '{1, 1, 1, 1};
        set_resp('1, '0, '1, 16'h0010);
        launch(4'hF, {16'h0004, 16'h0003, 16'h0002, 16'h0001});
        finish_frame(4, -1);
        chk("overrun_flag", 32'(overrun), 32'd1);
        chk("overrun_one_mix", 32'(n_mv), 32'd1);
        chk("overrun_mix_R", 32'(mix_R), 32'h004A);

        // Voice 1 never answered
        lat = '{3, 0, 3, 3};
        set_resp('1, '0, '1, '0);
        launch(4'hF, {16'h0400, 16'h0300, 16'h0200, 16'h0100});
        finish_frame(-1, -1);
        chk("timeout_flag", 32'(timeout_err), 32'd1);
        chk("timeout_issues", 32'(n_issue), 32'd4);
        chk("timeout_mix_L", 32'(mix_L), 32'h0800);

        // Reset during WAIT, then a normal frame
        lat = '{5, 5, 5, 5};
        launch(4'hF, {$urandom, $urandom});
        finish_frame(-1, 5);
        chk("reset_no_mix", 32'(n_mv), 32'd0);
        chk("reset_timeout_clr", 32'(timeout_err), 32'd0);
        lat = '{2, 2, 2, 2};
        set_resp('0, 16'h0100, '0, 16'h0200);
        launch(4'b0101, {$urandom, $urandom});
        finish_frame(-1, -1);
        chk("post_reset_mix_L", 32'(mix_L), 32'h0200);
        chk("post_reset_mix_R", 32'(mix_R), 32'h0400);

        // Randomized frames
        nfr = 0;
        while (nfr < 80 && cyc < MAXC - 400) begin
            for (int i = 0; i < NV; i++) begin
                r = int'($urandom_range(0, 9));
                case (r)
                    0:       lat[i] = 0;
                    1:       lat[i] = TO;
                    2:       lat[i] = TO + 1;
                    3:       lat[i] = TO + 2;
                    default: lat[i] = int'($urandom_range(1, 4));
                endcase
            end
            set_resp(($urandom_range(0, 3) == 0) ? 16'h0000 : 16'hFFFF, 16'($urandom),
                     ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'hFFFF, 16'($urandom));
            launch(NV'($urandom), {$urandom, $urandom});
            r = int'($urandom_range(0, 9));
            if (r == 0)      finish_frame(-1, int'($urandom_range(2, frame_end - f_cyc)));
            else if (r <= 2) finish_frame(int'($urandom_range(2, frame_end - f_cyc)), -1);
            else             finish_frame(-1, -1);
            repeat ($urandom_range(0, 2)) begin tick(); rnd_inputs(); end
            nfr++;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #(MAXC * 10);
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1);
    end

endmodule
